// File: rtl/ghr_checkpoint_unit.sv
// Global branch history unit: speculative and committed history registers plus
// an in-order FIFO of pre-prediction snapshots, one per in-flight branch. The
// head snapshot feeds target-cache training and repairs speculative history
// on a mispredict or a flush.
module ghr_checkpoint_unit #(
  parameter int HIST_W = 10,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pred_valid,
  input  logic              pred_taken,
  output logic              pred_ready,
  output logic [HIST_W-1:0] spec_bhr,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic              resolve_mispredict,
  output logic [HIST_W-1:0] resolve_bhr,
  output logic [HIST_W-1:0] arch_bhr,
  input  logic              flush,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  logic [HIST_W-1:0] entry_q [DEPTH];
  logic [HIST_W-1:0] spec_q, spec_d;
  logic [HIST_W-1:0] arch_q, arch_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  logic              pop_s;
  logic              mispredict_s;
  logic              kill_s;
  logic              push_s;
  logic [HIST_W-1:0] head_s;
  logic [HIST_W-1:0] commit_s;

  // A resolve on an empty queue is ignored, so only a real pop may mispredict.
  assign pop_s        = resolve_valid & ~empty_q;
  assign mispredict_s = pop_s & resolve_mispredict;
  assign kill_s       = flush | mispredict_s;
  assign push_s       = pred_valid & ~full_q & ~kill_s;
  assign head_s       = entry_q[rd_ptr_q];
  assign commit_s     = {head_s[HIST_W-2:0], resolve_taken};

  assign pred_ready  = ~full_q;
  assign spec_bhr    = spec_q;
  assign arch_bhr    = arch_q;
  assign resolve_bhr = head_s;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;

  // Next-state: commit on pop, then flush > mispredict > normal push/pop.
  always_comb begin
    spec_d   = spec_q;
    arch_d   = arch_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_s) begin
      arch_d   = commit_s;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      arch_d   = arch_q;
      rd_ptr_d = rd_ptr_q;
    end
    if (flush) begin
      // Restore to the committed history including any same-cycle pop.
      spec_d   = arch_d;
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
    end else if (mispredict_s) begin
      spec_d   = commit_s;
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
    end else begin
      if (push_s) begin
        spec_d   = {spec_q[HIST_W-2:0], pred_taken};
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        spec_d   = spec_q;
        wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == (PTR_W+1)'(DEPTH));
    empty_d = (count_d == (PTR_W+1)'(0));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spec_q   <= '0;
      arch_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      spec_q   <= spec_d;
      arch_q   <= arch_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Snapshot storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      entry_q[wr_ptr_q] <= spec_q;
    end
  end

endmodule

// File: tb/tb_ghr_checkpoint_unit.sv
// Directed self-checking bench for ghr_checkpoint_unit.
module tb_ghr_checkpoint_unit;

  logic       clk;
  logic       resetn;
  logic       pred_valid;
  logic       pred_taken;
  logic       pred_ready;
  logic [9:0] spec_bhr;
  logic       resolve_valid;
  logic       resolve_taken;
  logic       resolve_mispredict;
  logic [9:0] resolve_bhr;
  logic [9:0] arch_bhr;
  logic       flush;
  logic [4:0] count;
  logic       full;
  logic       empty;

  int n_checks;
  int n_pass;

  ghr_checkpoint_unit #(.HIST_W(10), .DEPTH(16), .PTR_W(4)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .pred_valid        (pred_valid),
    .pred_taken        (pred_taken),
    .pred_ready        (pred_ready),
    .spec_bhr          (spec_bhr),
    .resolve_valid     (resolve_valid),
    .resolve_taken     (resolve_taken),
    .resolve_mispredict(resolve_mispredict),
    .resolve_bhr       (resolve_bhr),
    .arch_bhr          (arch_bhr),
    .flush             (flush),
    .count             (count),
    .full              (full),
    .empty             (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pred_valid = 1'b0; pred_taken = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_mispredict = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (spec_bhr !== 10'h000 || arch_bhr !== 10'h000 || count !== 5'd0 ||
        empty !== 1'b1 || full !== 1'b0 || pred_ready !== 1'b1)
      $display("FAIL reset: spec=%h arch=%h count=%0d empty=%b full=%b ready=%b, want 000 000 0 1 0 1",
               spec_bhr, arch_bhr, count, empty, full, pred_ready);
    else n_pass++;
    resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_mispredict = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (spec_bhr !== 10'h000 || arch_bhr !== 10'h000 || count !== 5'd0 || empty !== 1'b1)
      $display("FAIL resolve_empty: spec=%h arch=%h count=%0d empty=%b, want 000 000 0 1",
               spec_bhr, arch_bhr, count, empty);
    else n_pass++;
  endtask

  task automatic test_push();
    logic [2:0]  dirs;
    logic [29:0] exp_spec;
    dirs = 3'b101;               // T,N,T in order dirs[2],dirs[1],dirs[0]
    exp_spec = {10'h001, 10'h002, 10'h005};
    for (int i = 0; i < 3; i++) begin
      pred_valid = 1'b1; pred_taken = dirs[2-i];
      step();
      n_checks++;
      if (spec_bhr !== exp_spec[29-10*i -: 10])
        $display("FAIL push_spec[%0d]: got %h want %h", i, spec_bhr, exp_spec[29-10*i -: 10]);
      else n_pass++;
    end
    idle_inputs();
    n_checks++;
    if (count !== 5'd3 || empty !== 1'b0)
      $display("FAIL push_count: got %0d empty=%b want 3 0", count, empty);
    else n_pass++;
  endtask

  task automatic test_resolve();
    logic [2:0]  dirs;
    logic [29:0] exp_head;
    dirs = 3'b101;
    exp_head = {10'h000, 10'h001, 10'h002};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (resolve_bhr !== exp_head[29-10*i -: 10])
        $display("FAIL resolve_head[%0d]: got %h want %h", i, resolve_bhr, exp_head[29-10*i -: 10]);
      else n_pass++;
      resolve_valid = 1'b1; resolve_taken = dirs[2-i];
      step();
    end
    idle_inputs();
    n_checks++;
    if (arch_bhr !== 10'h005 || empty !== 1'b1 || spec_bhr !== 10'h005 || count !== 5'd0)
      $display("FAIL resolve_end: arch=%h empty=%b spec=%h count=%0d, want 005 1 005 0",
               arch_bhr, empty, spec_bhr, count);
    else n_pass++;
  endtask

  task automatic test_mispredict();
    for (int i = 0; i < 3; i++) begin
      pred_valid = 1'b1; pred_taken = 1'b1;
      step();
    end
    idle_inputs();
    n_checks++;
    if (spec_bhr !== 10'h02F || count !== 5'd3 || resolve_bhr !== 10'h005)
      $display("FAIL mp_setup: spec=%h count=%0d head=%h, want 02F 3 005", spec_bhr, count, resolve_bhr);
    else n_pass++;
    resolve_valid = 1'b1; resolve_taken = 1'b0; resolve_mispredict = 1'b1;
    pred_valid = 1'b1; pred_taken = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (spec_bhr !== 10'h00A || arch_bhr !== 10'h00A || count !== 5'd0 || empty !== 1'b1)
      $display("FAIL mispredict: spec=%h arch=%h count=%0d empty=%b, want 00A 00A 0 1",
               spec_bhr, arch_bhr, count, empty);
    else n_pass++;
  endtask

  task automatic test_fill();
    // 16 taken preds from 0x00A: pointers wrap (rd/wr start at 4).
    for (int i = 0; i < 16; i++) begin
      pred_valid = 1'b1; pred_taken = 1'b1;
      step();
      if (i == 14) begin
        n_checks++;
        if (full !== 1'b0 || count !== 5'd15)
          $display("FAIL fill_15: full=%b count=%0d want 0 15", full, count);
        else n_pass++;
      end
    end
    idle_inputs();
    n_checks++;
    if (full !== 1'b1 || pred_ready !== 1'b0 || count !== 5'd16 || spec_bhr !== 10'h3FF)
      $display("FAIL fill_full: full=%b ready=%b count=%0d spec=%h, want 1 0 16 3FF",
               full, pred_ready, count, spec_bhr);
    else n_pass++;
    pred_valid = 1'b1; pred_taken = 1'b0;
    step();
    idle_inputs();
    n_checks++;
    if (spec_bhr !== 10'h3FF || count !== 5'd16)
      $display("FAIL refused_pred: spec=%h count=%0d want 3FF 16", spec_bhr, count);
    else n_pass++;
    n_checks++;
    if (resolve_bhr !== 10'h00A)
      $display("FAIL full_head: got %h want 00A", resolve_bhr);
    else n_pass++;
    pred_valid = 1'b1; pred_taken = 1'b0;
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (count !== 5'd15 || full !== 1'b0 || spec_bhr !== 10'h3FF || arch_bhr !== 10'h015)
      $display("FAIL full_pop: count=%0d full=%b spec=%h arch=%h, want 15 0 3FF 015",
               count, full, spec_bhr, arch_bhr);
    else n_pass++;
    pred_valid = 1'b1; pred_taken = 1'b0;
    step();
    idle_inputs();
    n_checks++;
    if (count !== 5'd16 || full !== 1'b1 || spec_bhr !== 10'h3FE)
      $display("FAIL refill: count=%0d full=%b spec=%h, want 16 1 3FE", count, full, spec_bhr);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // Head is the second snapshot 0x015.
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    step();
    idle_inputs();
    n_checks++;
    if (arch_bhr !== 10'h02A || count !== 5'd15 || resolve_bhr !== 10'h02B)
      $display("FAIL b2b_pop: arch=%h count=%0d head=%h, want 02A 15 02B", arch_bhr, count, resolve_bhr);
    else n_pass++;
    pred_valid = 1'b1; pred_taken = 1'b1;
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (arch_bhr !== 10'h057 || count !== 5'd15 || spec_bhr !== 10'h3FD)
      $display("FAIL b2b_pushpop: arch=%h count=%0d spec=%h, want 057 15 3FD", arch_bhr, count, spec_bhr);
    else n_pass++;
  endtask

  task automatic test_flush_and_async_reset();
    do_reset();
    pred_valid = 1'b1;
    pred_taken = 1'b1; step();
    pred_taken = 1'b0; step();
    pred_taken = 1'b1; step();
    idle_inputs();
    resolve_valid = 1'b1;
    resolve_taken = 1'b1; step();
    resolve_taken = 1'b0; step();
    resolve_taken = 1'b1; step();
    idle_inputs();
    pred_valid = 1'b1; pred_taken = 1'b0;
    step();
    idle_inputs();
    n_checks++;
    if (resolve_bhr !== 10'h005 || spec_bhr !== 10'h00A || arch_bhr !== 10'h005 || count !== 5'd1)
      $display("FAIL flush_setup: head=%h spec=%h arch=%h count=%0d, want 005 00A 005 1",
               resolve_bhr, spec_bhr, arch_bhr, count);
    else n_pass++;
    flush = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1;
    pred_valid = 1'b1; pred_taken = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (arch_bhr !== 10'h00B || spec_bhr !== 10'h00B || empty !== 1'b1 || count !== 5'd0)
      $display("FAIL flush: arch=%h spec=%h empty=%b count=%0d, want 00B 00B 1 0",
               arch_bhr, spec_bhr, empty, count);
    else n_pass++;
    pred_valid = 1'b1; pred_taken = 1'b1;
    step();
    step();
    n_checks++;
    if (count !== 5'd2 || spec_bhr !== 10'h02F)
      $display("FAIL pre_async: count=%0d spec=%h, want 2 02F", count, spec_bhr);
    else n_pass++;
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (spec_bhr !== 10'h000 || arch_bhr !== 10'h000 || count !== 5'd0 ||
        empty !== 1'b1 || full !== 1'b0 || pred_ready !== 1'b1)
      $display("FAIL async_reset: spec=%h arch=%h count=%0d empty=%b full=%b ready=%b, want 000 000 0 1 0 1",
               spec_bhr, arch_bhr, count, empty, full, pred_ready);
    else n_pass++;
    idle_inputs();
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    idle_inputs();
    test_reset();
    test_push();
    test_resolve();
    test_mispredict();
    test_fill();
    test_back_to_back();
    test_flush_and_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
